// File: rtl/amt_pkg.sv
// Shared types and defaults for the architectural map table.
//   amt_state_t   : sequencer states (init sweep, idle, repair stream)
//   AMT_*         : default table geometry
//   N_GROUPS      : number of N_PACKETS-wide groups in the default table
//   amt_pkt_idx_t : one repair packet's worth of logical indices
//   grp_bits()    : width of the group/packet counters for a geometry
package amt_pkg;

    typedef enum logic [1:0] {
        AMT_INIT,
        AMT_IDLE,
        AMT_REPAIR
    } amt_state_t;

    localparam int AMT_DEPTH     = 64;
    localparam int AMT_INDEX     = 6;
    localparam int AMT_WIDTH     = 8;
    localparam int AMT_N_WR      = 4;
    localparam int AMT_N_RD      = 4;
    localparam int AMT_N_PACKETS = 8;

    localparam int N_GROUPS = AMT_DEPTH / AMT_N_PACKETS;

    typedef logic [AMT_N_PACKETS-1:0][AMT_INDEX-1:0] amt_pkt_idx_t;

    // Counter width; kept at least 1 so a single-group table still elaborates.
    function automatic int grp_bits(input int depth, input int npk);
        return (depth / npk > 1) ? $clog2(depth / npk) : 1;
    endfunction

endpackage

// File: rtl/amt_storage.sv
// Flip-flop backing store for the AMT.
//   clk                 : clock
//   init_en_i/init_grp_i: write identity mapping to every entry of one group
//   wr_en_i/addr/data   : N_WR commit write ports, highest lane wins on a tie
//   rd_addr_i/rd_data_o : N_RD combinational read ports
//   rep_grp_i/rep_data_o: N_PACKETS combinational reads of one aligned group
// Contents need no reset: the init sweep rewrites every entry.
module amt_storage #(
    parameter int DEPTH     = 64,
    parameter int INDEX     = 6,
    parameter int WIDTH     = 8,
    parameter int N_WR      = 4,
    parameter int N_RD      = 4,
    parameter int N_PACKETS = 8,
    parameter int GW        = 3
) (
    input  logic                        clk,
    input  logic                        init_en_i,
    input  logic [GW-1:0]               init_grp_i,
    input  logic [N_WR-1:0]             wr_en_i,
    input  logic [N_WR*INDEX-1:0]       wr_addr_i,
    input  logic [N_WR*WIDTH-1:0]       wr_data_i,
    input  logic [N_RD*INDEX-1:0]       rd_addr_i,
    output logic [N_RD*WIDTH-1:0]       rd_data_o,
    input  logic [GW-1:0]               rep_grp_i,
    output logic [N_PACKETS*WIDTH-1:0]  rep_data_o
);

    localparam int PW = $clog2(N_PACKETS);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (init_en_i) begin
            for (int j = 0; j < N_PACKETS; j++) begin
                mem_d[{init_grp_i, PW'(j)}] = WIDTH'({init_grp_i, PW'(j)});
            end
        end
        // Ascending lane order: a later lane overwrites an earlier one.
        for (int k = 0; k < N_WR; k++) begin
            if (wr_en_i[k]) begin
                mem_d[wr_addr_i[k*INDEX +: INDEX]] = wr_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        assign rd_data_o[k*WIDTH +: WIDTH] = mem_q[rd_addr_i[k*INDEX +: INDEX]];
    end

    for (genvar j = 0; j < N_PACKETS; j++) begin : g_rep
        localparam logic [PW-1:0] SLOT = PW'(j);
        assign rep_data_o[j*WIDTH +: WIDTH] = mem_q[{rep_grp_i, SLOT}];
    end

endmodule

// File: rtl/amt_repair_table.sv
// Architectural map table with init sequencer and repair streamer.
//   clk, reset          : clock, synchronous active-high reset
//   rdAddr_i/rdData_o   : combinational rename-side reads
//   wrEn_i/wrAddr_i/wrData_i/laneActive_i : commit writes (ignored in INIT)
//   repairReq_i         : start (or restart) a full-table stream
//   repairValid_o/Ready_i/Idx_o/Data_o/Last_o : packetised stream to the RMT
//   busy_o              : not idle
//   ready_o             : table initialised
module amt_repair_table
    import amt_pkg::*;
#(
    parameter int DEPTH     = AMT_DEPTH,
    parameter int INDEX     = AMT_INDEX,
    parameter int WIDTH     = AMT_WIDTH,
    parameter int N_WR      = AMT_N_WR,
    parameter int N_RD      = AMT_N_RD,
    parameter int N_PACKETS = AMT_N_PACKETS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_RD*INDEX-1:0]       rdAddr_i,
    output logic [N_RD*WIDTH-1:0]       rdData_o,
    input  logic [N_WR-1:0]             wrEn_i,
    input  logic [N_WR*INDEX-1:0]       wrAddr_i,
    input  logic [N_WR*WIDTH-1:0]       wrData_i,
    input  logic [N_WR-1:0]             laneActive_i,
    input  logic                        repairReq_i,
    output logic                        repairValid_o,
    input  logic                        repairReady_i,
    output logic [N_PACKETS*INDEX-1:0]  repairIdx_o,
    output logic [N_PACKETS*WIDTH-1:0]  repairData_o,
    output logic                        repairLast_o,
    output logic                        busy_o,
    output logic                        ready_o
);

    localparam int GROUPS = DEPTH / N_PACKETS;
    localparam int GW     = grp_bits(DEPTH, N_PACKETS);
    localparam int PW     = $clog2(N_PACKETS);
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

    amt_state_t    state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] p_q, p_d;
    logic          pend_q, pend_d;

    logic [N_WR-1:0]            wr_en;
    logic [N_PACKETS*WIDTH-1:0] rep_data;
    logic                       rep_valid;

    assign wr_en = (state_q != AMT_INIT) ? (wrEn_i & laneActive_i) : '0;

    amt_storage #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .N_WR(N_WR),
        .N_RD(N_RD), .N_PACKETS(N_PACKETS), .GW(GW)
    ) u_storage (
        .clk        (clk),
        .init_en_i  (state_q == AMT_INIT),
        .init_grp_i (g_q),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wrAddr_i),
        .wr_data_i  (wrData_i),
        .rd_addr_i  (rdAddr_i),
        .rd_data_o  (rdData_o),
        .rep_grp_i  (p_q),
        .rep_data_o (rep_data)
    );

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        pend_d  = pend_q;
        case (state_q)
            AMT_INIT: begin
                // A request during the sweep waits here, including one on the final sweep cycle.
                pend_d = pend_q | repairReq_i;
                if (g_q == LAST_GRP) begin
                    p_d     = '0;
                    pend_d  = 1'b0;
                    state_d = (pend_q | repairReq_i) ? AMT_REPAIR : AMT_IDLE;
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            AMT_IDLE: begin
                if (repairReq_i) begin
                    state_d = AMT_REPAIR;
                    p_d     = '0;
                end
            end
            AMT_REPAIR: begin
                // Restart takes priority; the handshake this cycle still completes upstream.
                if (repairReq_i) begin
                    p_d = '0;
                end else if (repairReady_i) begin
                    if (p_q == LAST_GRP) state_d = AMT_IDLE;
                    else                 p_d     = p_q + 1'b1;
                end
            end
            default: state_d = AMT_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AMT_INIT;
            g_q     <= '0;
            p_q     <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            pend_q  <= pend_d;
        end
    end

    assign rep_valid     = (state_q == AMT_REPAIR);
    assign repairValid_o = rep_valid;
    assign repairLast_o  = rep_valid & (p_q == LAST_GRP);
    assign repairData_o  = rep_valid ? rep_data : '0;
    assign busy_o        = (state_q != AMT_IDLE);
    assign ready_o       = (state_q != AMT_INIT);

    for (genvar j = 0; j < N_PACKETS; j++) begin : g_idx
        localparam logic [PW-1:0] SLOT = PW'(j);
        assign repairIdx_o[j*INDEX +: INDEX] = rep_valid ? INDEX'({p_q, SLOT}) : '0;
    end

endmodule

// File: tb/tb_amt_repair_table.sv
module tb_amt_repair_table;

    localparam int DEPTH = 64, INDEX = 6, WIDTH = 8, N_WR = 4, N_RD = 4, NP = 8;
    localparam int NG = DEPTH / NP;

    logic clk = 1'b0;
    logic reset;
    logic [N_RD*INDEX-1:0] rd_addr;
    logic [N_RD*WIDTH-1:0] rd_data;
    logic [N_WR-1:0]       wr_en, lane_act;
    logic [N_WR*INDEX-1:0] wr_addr;
    logic [N_WR*WIDTH-1:0] wr_data;
    logic                  req, rdy, vld, last, busy, ready;
    logic [NP*INDEX-1:0]   r_idx;
    logic [NP*WIDTH-1:0]   r_data;

    always #5 clk = ~clk;

    amt_repair_table dut (
        .clk(clk), .reset(reset),
        .rdAddr_i(rd_addr), .rdData_o(rd_data),
        .wrEn_i(wr_en), .wrAddr_i(wr_addr), .wrData_i(wr_data), .laneActive_i(lane_act),
        .repairReq_i(req), .repairValid_o(vld), .repairReady_i(rdy),
        .repairIdx_o(r_idx), .repairData_o(r_data), .repairLast_o(last),
        .busy_o(busy), .ready_o(ready)
    );

    int compared = 0, mismatched = 0;

    // Reference model: table contents plus stream/initialisation progress.
    logic [7:0] mdl [DEPTH];
    bit known = 0;
    int init_left = 0;
    bit pend = 0, strm = 0;
    int pkt = 0;

    logic s_vld, s_last, s_busy, s_ready, s_hs;
    logic [NP*INDEX-1:0] s_idx;
    logic [NP*WIDTH-1:0] s_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            known = 1; init_left = NG; pend = 0; strm = 0; pkt = 0;
        end else if (known) begin
            if (init_left > 0) begin
                int base;
                base = (NG - init_left) * NP;
                for (int i = 0; i < NP; i++) mdl[base+i] = 8'(base + i);
                pend = pend | req;
                init_left--;
                if (init_left == 0 && pend) begin strm = 1; pkt = 0; pend = 0; end
            end else begin
                for (int k = 0; k < N_WR; k++)
                    if (wr_en[k] && lane_act[k]) mdl[wr_addr[k*INDEX +: INDEX]] = wr_data[k*WIDTH +: WIDTH];
                if (req) begin
                    strm = 1; pkt = 0;
                end else if (strm && rdy) begin
                    if (pkt == NG - 1) strm = 0;
                    else pkt++;
                end
            end
        end
    endtask

    task automatic step();
        logic [NP*INDEX-1:0] e_idx;
        logic [NP*WIDTH-1:0] e_data;
        @(negedge clk);
        s_vld = vld; s_last = last; s_busy = busy; s_ready = ready;
        s_idx = r_idx; s_data = r_data; s_hs = vld & rdy;
        if (known) begin
            chk("ready_o", 64'(ready), 64'(init_left == 0));
            chk("busy_o", 64'(busy), 64'((init_left > 0) || strm));
            chk("repairValid_o", 64'(vld), 64'(strm));
            chk("repairLast_o", 64'(last), 64'(strm && pkt == NG - 1));
            e_idx = '0; e_data = '0;
            if (strm) begin
                for (int j = 0; j < NP; j++) begin
                    e_idx[j*INDEX +: INDEX] = INDEX'(pkt * NP + j);
                    e_data[j*WIDTH +: WIDTH] = mdl[pkt * NP + j];
                end
                chk("repairData_o", 64'(r_data), 64'(e_data));
            end
            chk("repairIdx_o", 64'(r_idx), 64'(e_idx));
            if (init_left == 0)
                for (int k = 0; k < N_RD; k++)
                    chk("rdData_o", 64'(rd_data[k*WIDTH +: WIDTH]), 64'(mdl[rd_addr[k*INDEX +: INDEX]]));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        rdy = 1;
        for (n = 0; n < 40; n++) begin
            step();
            if (!s_busy) break;
        end
        chk(tag, 64'(n < 40), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hs_cnt, last_cnt, last_hs_n, fall_n;
        logic [NP*WIDTH-1:0] idv;

        reset = 1; rd_addr = '0; wr_en = '0; lane_act = '1; wr_addr = '0; wr_data = '0;
        req = 0; rdy = 0;

        // Reset, then count cycles until the table reports ready.
        step(); step();
        reset = 0;
        rd_addr = {6'd0, 6'd0, 6'd63, 6'd5};
        n = 0;
        while (n < 20) begin
            step();
            if (s_ready) break;
            n++;
        end
        chk("init_cycles", 64'(n), 64'd8);
        chk("rd_addr5", 64'(rd_data[7:0]), 64'd5);
        chk("rd_addr63", 64'(rd_data[15:8]), 64'd63);

        // Same-address conflict and an inactive lane.
        wr_en = 4'b0111; lane_act = 4'b1101;
        wr_addr = {6'd0, 6'd3, 6'd4, 6'd3};
        wr_data = {8'h00, 8'h22, 8'h55, 8'h11};
        step();
        wr_en = '0; lane_act = '1;
        rd_addr = {6'd0, 6'd0, 6'd4, 6'd3};
        #1;
        chk("conflict_lane2", 64'(rd_data[7:0]), 64'h22);
        chk("inactive_lane", 64'(rd_data[15:8]), 64'h04);

        // Fill with 0x40+i, then stream with alternating ready.
        for (int s = 0; s < 16; s++) begin
            wr_en = '1;
            for (int k = 0; k < N_WR; k++) begin
                wr_addr[k*INDEX +: INDEX] = 6'(4 * s + k);
                wr_data[k*WIDTH +: WIDTH] = 8'(8'h40 + 4 * s + k);
            end
            step();
        end
        wr_en = '0; req = 1; rdy = 0;
        step();
        req = 0;
        hs_cnt = 0; last_cnt = 0; last_hs_n = -100; fall_n = -1;
        for (int i = 0; i < 40; i++) begin
            rdy = (i % 2 == 0);
            step();
            if (s_hs) begin
                chk("pkt_order", 64'(s_idx[INDEX-1:0]), 64'(hs_cnt * NP));
                chk("pkt_data0", 64'(s_data[7:0]), 64'(8'h40 + 8 * hs_cnt));
                if (s_last) last_cnt++;
                hs_cnt++;
                last_hs_n = i;
            end
            if (!s_busy) begin fall_n = i; break; end
        end
        chk("hs_count", 64'(hs_cnt), 64'd8);
        chk("last_count", 64'(last_cnt), 64'd1);
        chk("busy_fall", 64'(fall_n - last_hs_n), 64'd1);

        // Request during INIT is held and serviced when the sweep ends.
        rdy = 0; reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 3; i++) step();
        req = 1;
        step();
        req = 0;
        n = 0;
        while (n < 20) begin
            step();
            if (s_vld) break;
            n++;
        end
        for (int j = 0; j < NP; j++) idv[j*WIDTH +: WIDTH] = 8'(j);
        chk("init_req_valid", 64'(s_vld), 64'd1);
        chk("init_req_ready", 64'(s_ready), 64'd1);
        chk("init_req_pkt0", 64'(s_data), 64'(idv));
        drain("drain_init_req");

        // Restart mid-stream, then reset mid-stream.
        req = 1; rdy = 1;
        step();
        req = 0;
        for (int i = 0; i < 4; i++) step();
        req = 1;
        step();
        chk("pkt4_shown", 64'(s_idx[INDEX-1:0]), 64'd32);
        req = 0; rdy = 0;
        step();
        chk("restart_valid", 64'(s_vld), 64'd1);
        chk("restart_p0", 64'(s_idx[INDEX-1:0]), 64'd0);
        rdy = 1;
        step(); step();
        last_cnt = 0;
        reset = 1;
        step();
        reset = 0;
        step();
        chk("rst_valid", 64'(s_vld), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd0);
        if (s_last) last_cnt++;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_last) last_cnt++;
        end
        chk("no_last_after_reset", 64'(last_cnt), 64'd0);
        chk("reinit_ready", 64'(s_ready), 64'd1);

        // Write during repair: old value in packet 0, new value in next stream.
        rdy = 0; req = 1;
        step();
        req = 0;
        step();
        rdy = 1;
        step();
        chk("p0_handshake", 64'(s_hs), 64'd1);
        chk("p0_old_val", 64'(s_data[23:16]), 64'h02);
        rdy = 0; wr_en = 4'b0001;
        wr_addr[5:0] = 6'd2; wr_data[7:0] = 8'h99;
        step();
        wr_en = '0;
        drain("drain_wr_repair");
        req = 1; rdy = 0;
        step();
        req = 0;
        step();
        chk("p0_new_val", 64'(s_data[23:16]), 64'h99);
        drain("drain_second");

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rd_addr  = 24'($urandom);
            wr_en    = 4'($urandom);
            lane_act = 4'($urandom);
            for (int k = 0; k < N_WR; k++)
                wr_addr[k*INDEX +: INDEX] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
            wr_data  = 32'($urandom);
            req      = ($urandom_range(0, 19) == 0);
            rdy      = 1'($urandom_range(0, 1));
            reset    = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 0; req = 0; wr_en = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
